// File: rtl/struct_field_arbiter.sv
// struct_field_arbiter
//
// Holds one three-field record {xx[7:0], yy, zz[15:0]} that two requesters
// (A and B) update through valid/ready handshakes. A round-robin pointer
// picks one requester per cycle when both are valid. The granted operation
// (write or add) lands in the register on the same edge that completes the
// handshake.
//
// Ports
//   clk, rst_n              clock; synchronous active-low reset
//   a_valid/a_ready         requester A handshake
//   a_field, a_op, a_data   A operation: field 0=xx 1=yy 2=zz 3=illegal,
//                           op 0=write 1=add, 16-bit operand
//   b_*                     same for requester B
//   out_xx/out_yy/out_zz    current field values
//   upd_valid               one-cycle pulse: a field value changed
//   upd_field, upd_src      field index and requester of that change (held)
//   err                     one-cycle pulse: an illegal field op was accepted
//   upd_count               wrapping count of accepted legal operations
module struct_field_arbiter #(
    parameter logic [7:0]  INIT_XX = 8'h00,
    parameter logic        INIT_YY = 1'b0,
    parameter logic [15:0] INIT_ZZ = 16'h0000,
    parameter bit          ZZ_SAT  = 1'b1,
    parameter int          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [1:0]       a_field,
    input  logic             a_op,
    input  logic [15:0]      a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       b_field,
    input  logic             b_op,
    input  logic [15:0]      b_data,
    output logic [7:0]       out_xx,
    output logic             out_yy,
    output logic [15:0]      out_zz,
    output logic             upd_valid,
    output logic [1:0]       upd_field,
    output logic             upd_src,
    output logic             err,
    output logic [CNT_W-1:0] upd_count
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t             prio_q;
    prio_t             prio_d;

    logic [7:0]        xx_p1;
    logic              yy_p1;
    logic [15:0]       zz_p1;
    logic              upd_valid_p1;
    logic [1:0]        upd_field_p1;
    logic              upd_src_p1;
    logic              err_p1;
    logic [CNT_W-1:0]  cnt_p1;

    logic              hs;
    logic              sel_src;
    logic [1:0]        sel_field;
    logic              sel_op;
    logic [15:0]       sel_data;
    logic [7:0]        xx_nxt;
    logic              yy_nxt;
    logic [15:0]       zz_nxt;
    logic              changed;

    // 17-bit add on zz, clamped to all-ones when saturation is enabled.
    function automatic logic [15:0] zz_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (ZZ_SAT && sum[16])
            zz_add = 16'hFFFF;
        else
            zz_add = sum[15:0];
    endfunction

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (!rst_n)
            prio_q <= PRIO_A;
        else
            prio_q <= prio_d;
    end

    // Grant and pointer update: the pointer moves to whichever side lost.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        prio_d  = prio_q;
        if (rst_n) begin
            if (a_valid && (!b_valid || prio_q == PRIO_A))
                a_ready = 1'b1;
            else if (b_valid)
                b_ready = 1'b1;
            if (a_ready)
                prio_d = PRIO_B;
            else if (b_ready)
                prio_d = PRIO_A;
        end
    end

    // Granted operand and candidate field values
    always_comb begin
        hs        = a_ready | b_ready;
        sel_src   = b_ready;
        sel_field = b_ready ? b_field : a_field;
        sel_op    = b_ready ? b_op    : a_op;
        sel_data  = b_ready ? b_data  : a_data;

        xx_nxt = sel_op ? (xx_p1 + sel_data[7:0]) : sel_data[7:0];
        yy_nxt = sel_op ? (yy_p1 ^ sel_data[0])   : sel_data[0];
        zz_nxt = sel_op ? zz_add(zz_p1, sel_data) : sel_data;

        changed = 1'b0;
        case (sel_field)
            2'd0:    changed = (xx_nxt != xx_p1);
            2'd1:    changed = (yy_nxt != yy_p1);
            2'd2:    changed = (zz_nxt != zz_p1);
            default: changed = 1'b0;
        endcase
    end

    // Stage p1: field register, notifications and counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xx_p1        <= INIT_XX;
            yy_p1        <= INIT_YY;
            zz_p1        <= INIT_ZZ;
            upd_valid_p1 <= 1'b0;
            upd_field_p1 <= 2'd0;
            upd_src_p1   <= 1'b0;
            err_p1       <= 1'b0;
            cnt_p1       <= '0;
        end else begin
            upd_valid_p1 <= 1'b0;
            err_p1       <= 1'b0;
            if (hs) begin
                if (sel_field == 2'd3) begin
                    err_p1 <= 1'b1;
                end else begin
                    cnt_p1 <= cnt_p1 + CNT_W'(1);
                    case (sel_field)
                        2'd0:    xx_p1 <= xx_nxt;
                        2'd1:    yy_p1 <= yy_nxt;
                        2'd2:    zz_p1 <= zz_nxt;
                        default: ;
                    endcase
                    // upd_field/upd_src only move when a value really changed
                    if (changed) begin
                        upd_valid_p1 <= 1'b1;
                        upd_field_p1 <= sel_field;
                        upd_src_p1   <= sel_src;
                    end
                end
            end
        end
    end

    assign out_xx    = xx_p1;
    assign out_yy    = yy_p1;
    assign out_zz    = zz_p1;
    assign upd_valid = upd_valid_p1;
    assign upd_field = upd_field_p1;
    assign upd_src   = upd_src_p1;
    assign err       = err_p1;
    assign upd_count = cnt_p1;

endmodule

// File: doc/struct_field_arbiter.md
Name: struct_field_arbiter

Overview:
- Owns one struct register with three fields:
  - xx: byte, 8 bits.
  - yy: reg, 1 bit.
  - zz: shortint unsigned, 16 bits.
- Two requesters (A and B) share update access to it through valid/ready handshakes.
- A round-robin arbiter grants at most one field operation per cycle and applies it in the registered datapath.
- The block also issues update notifications, error pulses and a wrapping update counter for downstream consumers.

Parameters:
- INIT_XX, 8'h00, reset value of field xx.
- INIT_YY, 1'b0, reset value of field yy.
- INIT_ZZ, 16'h0000, reset value of field zz.
- ZZ_SAT, 1, 1 = add on zz saturates at 16'hFFFF; 0 = add on zz wraps mod 2^16.
- CNT_W, 8, width of the update counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- a_valid  in  1  requester A has an operation.
- a_ready  out  1  requester A is granted this cycle.
- a_field  in  2  field select: 0 = xx, 1 = yy, 2 = zz, 3 = illegal.
- a_op  in  1  0 = write, 1 = add.
- a_data  in  16  operand.
- b_valid, b_ready, b_field, b_op, b_data: same as the A ports, for requester B.
- out_xx  out  8  current xx.
- out_yy  out  1  current yy.
- out_zz  out  16  current zz.
- upd_valid  out  1  one-cycle pulse: a field changed value last cycle.
- upd_field  out  2  field index for upd_valid; holds its value otherwise.
- upd_src  out  1  requester of that update: 0 = A, 1 = B.
- err  out  1  one-cycle pulse: an illegal field operation was accepted.
- upd_count  out  CNT_W  count of accepted legal operations; wraps.

Behaviour:
- Reset, on a rising clk edge with rst_n = 0:
  - Outputs: out_xx = INIT_XX, out_yy = INIT_YY, out_zz = INIT_ZZ, upd_valid = 0, upd_field = 0, upd_src = 0, err = 0, upd_count = 0.
  - Internal: round-robin pointer prio = A.
  - A reset asserted mid-stream discards the in-flight grant; no update occurs on that edge.
- Grant logic, combinational from the valid inputs and prio:
  - Only A valid: a_ready = 1. Only B valid: b_ready = 1.
  - Both valid: the side equal to prio gets ready. The other side sees ready = 0 and must hold valid, field, op and data stable until it is granted.
  - Neither valid: both readies = 0.
  - At most one ready is high per cycle. Both readies are 0 while rst_n = 0.
- Pointer: on any handshake (valid & ready), prio flips to the side that was not granted. With no handshake, prio holds.
- Datapath latency: the granted operation updates the field at the same edge that completes the handshake. out_* shows the new value in the next cycle.
- Write semantics:
  - xx = data[7:0].
  - yy = data[0].
  - zz = data[15:0].
- Add semantics:
  - xx = (xx + data[7:0]) mod 256.
  - yy = yy ^ data[0].
  - zz = 17-bit sum. If ZZ_SAT = 1 and the sum is above 16'hFFFF, zz = 16'hFFFF; otherwise zz = sum[15:0].
- Notification:
  - Every legal handshake increments upd_count; it wraps from 2^CNT_W − 1 to 0.
  - upd_valid pulses only if the field value actually changed. Example: writing the same value, or adding 0, counts but does not pulse.
  - upd_field and upd_src register alongside upd_valid.
- Illegal field (field = 3):
  - The handshake still completes and prio still flips.
  - No field changes and upd_count does not change.
  - err = 1 for exactly one cycle.
- Back-to-back handshakes are allowed every cycle, with no bubble.
- Unused operand bits (data[15:8] for xx, data[15:1] for yy) are ignored.

Test Plan:
- Reset with INIT_XX = 8'h5A, then release → out_xx = 8'h5A, out_yy = 0, out_zz = 0, upd_count = 0, all pulses low; prio = A.
- A and B both valid for 4 cycles, each with write xx of data 1, 2, 3, 4 in turn → grants A, B, A, B; out_xx sequence 1, 2, 3, 4; upd_src 0, 1, 0, 1; upd_count = 4.
- out_zz = 16'hFFF0, A adds 16'h0020: with ZZ_SAT = 1 → out_zz = 16'hFFFF, upd_valid = 1. With ZZ_SAT = 0 → out_zz = 16'h0010.
- B write zz with data equal to the current zz → upd_valid stays 0, upd_count +1.
- A field = 3 while B is idle → a_ready = 1, err pulses for one cycle, fields and upd_count unchanged; a following A/B conflict grants B.
- Assert rst_n = 0 during an A handshake at out_xx = 7 → no update applied; all outputs at their reset values the next cycle.
